// File: rtl/mult_share_ctrl_if.sv
// Request, multiplier and response signals of mult_share_ctrl.
// The slave modport is the controller's view; master is the surrounding logic.
interface mult_share_ctrl_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_p;
    logic [15:0] rsp_exact;
    logic        busy;
    logic [15:0] op_cnt;
    logic [15:0] err_cnt;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_p, rsp_ready,
        output req0_ready, req1_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, rsp_exact,
               busy, op_cnt, err_cnt
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_p, rsp_ready,
        input  req0_ready, req1_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, rsp_exact,
               busy, op_cnt, err_cnt
    );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin sharing of one multi-cycle-settle 8x8 multiplier between two requesters,
// with exact reference product and saturating operation/error counters.
module mult_share_ctrl #(
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    mult_share_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t      state_q;
    logic        last_q;
    logic [3:0]  settle_q;
    logic [7:0]  mul_a_q;
    logic [7:0]  mul_b_q;
    logic [15:0] rsp_p_q;
    logic [15:0] rsp_exact_q;
    logic        rsp_id_q;
    logic        rsp_valid_q;
    logic        busy_q;
    logic [15:0] op_cnt_q;
    logic [15:0] err_cnt_q;
    logic [15:0] op_cnt_d;
    logic [15:0] err_cnt_d;

    logic       grant;
    logic       accept;
    logic [7:0] sel_a;
    logic [7:0] sel_b;

    always_comb begin
        grant = '0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_q;
        end else begin
            grant = bus.req1_valid;
        end
    end

    // Ready is gated by rst so it stays low while reset is held, even with valid high.
    assign bus.req0_ready = (state_q == IDLE) && !rst && bus.req0_valid && !grant;
    assign bus.req1_ready = (state_q == IDLE) && !rst && bus.req1_valid && grant;
    assign accept = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);
    assign sel_a  = grant ? bus.req1_a : bus.req0_a;
    assign sel_b  = grant ? bus.req1_b : bus.req0_b;

    always_comb begin
        op_cnt_d  = op_cnt_q;
        err_cnt_d = err_cnt_q;
        if (op_cnt_q != '1) begin
            op_cnt_d = op_cnt_q + 16'd1;
        end
        if ((rsp_p_q != rsp_exact_q) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            settle_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_p_q     <= '0;
            rsp_exact_q <= '0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mul_a_q     <= sel_a;
                        mul_b_q     <= sel_b;
                        rsp_exact_q <= 16'(sel_a) * 16'(sel_b);
                        rsp_id_q    <= grant;
                        last_q      <= grant;
                        settle_q    <= 4'(SETTLE_CYC - 1);
                        busy_q      <= 1'b1;
                        state_q     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == '0) begin
                        rsp_p_q     <= bus.mul_p;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        op_cnt_q    <= op_cnt_d;
                        err_cnt_q   <= err_cnt_d;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.rsp_p     = rsp_p_q;
    assign bus.rsp_exact = rsp_exact_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.busy      = busy_q;
    assign bus.op_cnt    = op_cnt_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequencer and arbiter that shares one 8x8 approximate multiplier (`CSA_Mult_8bits`-style: combinational, ports A/B/P, multi-cycle settle) between two requesters. It grants requests round-robin, drives the multiplier operands, waits a programmable settle time, and captures the product. It returns the product with the exact reference product on one response channel, and keeps running operation and error counts for on-line accuracy monitoring.

## Interface
- `SETTLE_CYC`, default 4: cycles the multiplier output needs to settle after operands change; legal range 1..15.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req0_valid`  in  1  requester 0 has an operand pair
- `req0_ready`  out  1  requester 0 accepted this cycle
- `req0_a`, `req0_b`  in  8 each  requester 0 operands (unsigned)
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same for requester 1
- `mul_a`, `mul_b`  out  8 each  operands to shared multiplier
- `mul_p`  in  16  product from shared multiplier
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer takes response
- `rsp_id`  out  1  requester that issued the response
- `rsp_p`  out  16  captured approximate product
- `rsp_exact`  out  16  exact `a*b` of the same operands
- `busy`  out  1  high whenever state is not IDLE
- `op_cnt`  out  16  completed operations, saturating
- `err_cnt`  out  16  completed operations with `rsp_p != rsp_exact`, saturating

## Operation
- States: IDLE, SETTLE, RESP.
- IDLE:
  - Arbiter picks a grant from the valid requesters.
  - If both are valid, grant the one that is not `last`.
  - If one is valid, grant that one.
  - `reqN_ready` is high only for the granted requester, only in IDLE, combinationally.
  - Accept occurs on `reqN_valid && reqN_ready`. At that edge:
    - register operands into `mul_a`/`mul_b`
    - register the exact product `a*b` (16-bit, no overflow possible) into `rsp_exact`
    - set `rsp_id` to the granted requester and `last <= grant`
    - load `settle_cnt <= SETTLE_CYC-1`
    - go to SETTLE
- SETTLE:
  - Decrement `settle_cnt` each edge.
  - On the edge where `settle_cnt == 0`, capture `rsp_p <= mul_p` and go to RESP.
- RESP:
  - `rsp_valid` is high. `rsp_p`, `rsp_exact` and `rsp_id` are held stable.
  - On `rsp_valid && rsp_ready`:
    - `op_cnt` +1
    - `err_cnt` +1 if `rsp_p != rsp_exact`
    - both counters saturate at 16'hFFFF and do not wrap
    - go to IDLE
- `mul_a`/`mul_b` hold the last accepted operands in all states. They are not cleared after a response, so the multiplier does not toggle needlessly.
- Requests are never dropped. A requester holds `valid` and its operands until it sees `ready`. Operand changes while not granted have no effect.
- No new request is accepted in SETTLE or RESP, even if `rsp_ready` and a `valid` coincide with the RESP handshake. Acceptance resumes in IDLE on the next cycle.

## Timing
- Reset values:
  - state IDLE, `last` = 1 (requester 0 wins the first tie)
  - `mul_a`, `mul_b`, `rsp_p`, `rsp_exact`, `rsp_id` = 0
  - `rsp_valid`, `busy`, `req0_ready`, `req1_ready` = 0 while `rst` high
  - `op_cnt`, `err_cnt` = 0
- Latency:
  - Accept edge E0; `mul_a`/`mul_b` valid after E0.
  - `mul_p` is sampled at edge E0+SETTLE_CYC.
  - `rsp_valid` is high from after E0+SETTLE_CYC.
- Throughput: one operation per SETTLE_CYC+2 cycles at best (accept, settle, respond, return to IDLE).
- `busy` rises after E0 and falls after the response handshake edge.
- Reset asserted mid-operation (SETTLE or RESP):
  - In-flight operation is discarded, with no response and no counter update.
  - All outputs go to reset values asynchronously.
- `rsp_ready` high before `rsp_valid` has no effect. `rsp_ready` low holds RESP indefinitely.

## Test plan
- SETTLE_CYC=4, `mul_p` driven by an exact multiplier model; req0 a=200 b=100 → `req0_ready` high one cycle; `rsp_valid` 4 edges after accept; `rsp_id`=0, `rsp_p`=`rsp_exact`=20000; after handshake `op_cnt`=1, `err_cnt`=0.
- Both requesters valid continuously (req0 a=3 b=5, req1 a=255 b=255), `rsp_ready`=1 → grant order 0,1,0,1; responses 15, 65025, 15, 65025; accepts spaced 6 cycles apart.
- Bench drives `mul_p` = exact−1 for req1 a=16 b=16 → `rsp_p`=255, `rsp_exact`=256, `err_cnt` increments by 1, `op_cnt` increments by 1.
- `rsp_ready` held low 10 cycles in RESP with both requesters valid → `rsp_valid` stays high; `rsp_p`/`rsp_id` stable; both `reqN_ready` low; counters unchanged until the handshake.
- `rst` pulsed 2 cycles after accept (in SETTLE) → all outputs 0 immediately; no response; `op_cnt`=0. After release, first tie goes to requester 0.
- Edge operands a=0 b=255 and a=255 b=0 → `rsp_p`=`rsp_exact`=0, no error counted.
